startup_seq: RTL
================

STARTUP_SEQ -- requirements
Module: startup_seq

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of staged channel resets (range 1..8).
REQ-002 SHALL provide parameter CNT_W, default 16, sequence counter width.
REQ-003 SHALL provide parameter ROC_CYC, default 100, clk cycles gsr is held after the sequence starts (>=1).
REQ-004 SHALL provide parameter TOC_CYC, default 10, clk cycles gts is held after the sequence starts (1..ROC_CYC).
REQ-005 SHALL provide parameter STEP_CYC, default 8, clk cycles between successive channel releases (>=1).
REQ-006 SHALL provide parameter RELOCK_RST, default 1, 1 = lock loss in DONE re-runs the sequence, 0 = ignored.
REQ-007 SHALL provide port clk  input  1  sole clock, all state on rising edge.
REQ-008 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL provide port lock_in  input  1  asynchronous PLL-lock level, high = locked.
REQ-010 SHALL provide port restart  input  1  synchronous single-cycle restart request.
REQ-011 SHALL provide port gsr  output  1  global set/reset, active high.
REQ-012 SHALL provide port gts  output  1  global tristate, active high.
REQ-013 SHALL provide port ch_rst_n  output  NUM_CH  per-channel reset, active low.
REQ-014 SHALL provide port done  output  1  high when all outputs are released.

Function
REQ-015 SHALL synchronise lock_in through two flops to lock_s; all decisions use lock_s only.
REQ-016 SHALL implement states WAIT_LOCK, COUNT, DONE.
REQ-017 WAIT_LOCK: cnt held 0, all outputs asserted; move to COUNT on the edge where lock_s=1 (edge E0, cnt=0 after E0).
REQ-018 COUNT: cnt increments by 1 per edge, saturating at all-ones.
REQ-019 SHALL register all outputs; gts deasserts at edge E(TOC_CYC), gsr at edge E(ROC_CYC).
REQ-020 ch_rst_n[i] SHALL deassert at edge E(ROC_CYC + (i+1)*STEP_CYC); channel 0 first, in ascending order, one channel per release edge.
REQ-021 done SHALL assert and state SHALL become DONE at the same edge as ch_rst_n[NUM_CH-1] release.
REQ-022 lock_s=0 in COUNT: next edge SHALL return to WAIT_LOCK, cnt=0, all outputs reasserted.
REQ-023 lock_s=0 in DONE with RELOCK_RST=1: same as REQ-022; with RELOCK_RST=0: no effect.
REQ-024 restart=1 in COUNT or DONE: next edge SHALL return to WAIT_LOCK with all outputs reasserted; in WAIT_LOCK it has no effect.
REQ-025 restart and lock loss in the same cycle SHALL produce the single REQ-022 response.
REQ-026 An elaboration-time check SHALL fail if ROC_CYC + NUM_CH*STEP_CYC >= 2**CNT_W or TOC_CYC > ROC_CYC.
REQ-027 Outputs SHALL never deassert out of order (gts, gsr, ch 0..NUM_CH-1), including after restart.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state WAIT_LOCK, cnt=0, sync flops 0, gsr=1, gts=1, ch_rst_n=all 0, done=0.
REQ-029 rst_n deassertion SHALL take effect synchronously; the first sequence needs lock_s=1 (>=2 cycles after lock_in rises).
REQ-030 rst_n assertion mid-COUNT or in DONE SHALL reassert all outputs immediately, without waiting for clk.

Verification (NUM_CH=3, CNT_W=8, ROC_CYC=10, TOC_CYC=4, STEP_CYC=2)
REQ-031 Nominal: lock_in high from reset release -> E0 on 3rd edge after lock_in rises; gts low at E4, gsr low at E10, ch_rst_n 001 at E12, 011 at E14, 111 at E16 with done=1.
REQ-032 Lock drop at E7 (lock_s low before E7) -> all outputs reasserted next edge; on relock the sequence restarts from E0 with full timing.
REQ-033 restart pulse 5 cycles into DONE -> next edge gsr=1, gts=1, ch_rst_n=000, done=0; full sequence repeats if lock held.
REQ-034 RELOCK_RST=0, lock drop in DONE -> outputs unchanged, done stays 1; RELOCK_RST=1 -> reasserted as REQ-032.
REQ-035 rst_n pulsed low mid-COUNT between edges -> outputs reasserted asynchronously, before the next clk edge.
REQ-036 restart and lock drop in the same cycle of COUNT -> one reassert, state WAIT_LOCK, no glitch on any output.

Source files
------------

// File: rtl/startup_seq.sv
// Power-on startup sequencer: after PLL lock, releases gts, then gsr, then
// each channel reset in ascending order on fixed cycle offsets from lock.
module startup_seq #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ROC_CYC    = 100,
  parameter int unsigned TOC_CYC    = 10,
  parameter int unsigned STEP_CYC   = 8,
  parameter bit          RELOCK_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lock_in,
  input  logic              restart,
  output logic              gsr,
  output logic              gts,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              done
);

  // The whole sequence must fit in the counter and gts must release no later than gsr.
  if ((64'(ROC_CYC) + 64'(NUM_CH) * 64'(STEP_CYC)) >= (64'd1 << CNT_W) ||
      TOC_CYC > ROC_CYC) begin : g_bad_params
    $error("startup_seq: ROC_CYC + NUM_CH*STEP_CYC must be < 2**CNT_W and TOC_CYC <= ROC_CYC");
  end

  localparam logic [CNT_W-1:0] TOC_C  = CNT_W'(TOC_CYC);
  localparam logic [CNT_W-1:0] ROC_C  = CNT_W'(ROC_CYC);
  localparam logic [CNT_W-1:0] DONE_C = CNT_W'(ROC_CYC + NUM_CH * STEP_CYC);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_s1_q, lock_s_q;
  logic               gsr_q, gsr_d;
  logic               gts_q, gts_d;
  logic [NUM_CH-1:0]  ch_q, ch_d;
  logic               done_q, done_d;

  // Two-flop synchroniser for the asynchronous lock level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1_q <= 1'b0;
      lock_s_q  <= 1'b0;
    end else begin
      lock_s1_q <= lock_in;
      lock_s_q  <= lock_s1_q;
    end
  end

  // State, counter and registered outputs; reset asserts every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      gsr_q   <= 1'b1;
      gts_q   <= 1'b1;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gsr_q   <= gsr_d;
      gts_q   <= gts_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

  // Next state and next outputs; outputs are derived from the next count so
  // each release lands exactly on the edge where the count reaches its offset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gsr_d   = gsr_q;
    gts_d   = gts_q;
    ch_d    = ch_q;
    done_d  = done_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d  = '0;
        gsr_d  = 1'b1;
        gts_d  = 1'b1;
        ch_d   = '0;
        done_d = 1'b0;
        if (lock_s_q) state_d = COUNT;
      end
      COUNT: begin
        if (!lock_s_q || restart) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          gsr_d   = 1'b1;
          gts_d   = 1'b1;
          ch_d    = '0;
          done_d  = 1'b0;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          gts_d = (cnt_d < TOC_C);
          gsr_d = (cnt_d < ROC_C);
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_d[i] = (cnt_d >= CNT_W'(ROC_CYC + (i + 1) * STEP_CYC));
          end
          if (cnt_d >= DONE_C) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (restart || (RELOCK_RST && !lock_s_q)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          gsr_d   = 1'b1;
          gts_d   = 1'b1;
          ch_d    = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        gsr_d   = 1'b1;
        gts_d   = 1'b1;
        ch_d    = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign gsr      = gsr_q;
  assign gts      = gts_q;
  assign ch_rst_n = ch_q;
  assign done     = done_q;

endmodule
